// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencer with mult/div occupancy FSM
// Optional stall performance counter enabled by defining HAZARD_PERF_EN.
module pipe_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6,
    parameter int PERF_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_loaduse_req,
    input  logic              i_branch_req,
    input  logic              i_branch_taken,
    input  logic              i_ex_mult,
    input  logic              i_ex_div,
    input  logic              i_md_abort,
    output logic              o_pc_wr,
    output logic              o_ifid_wr,
    output logic              o_ifid_flush,
    output logic              o_idex_wr,
    output logic              o_idex_flush,
    output logic              o_exmem_flush,
    output logic              o_md_busy,
    output logic              o_md_done,
    output logic [PERF_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_md_req;
    logic             w_md_stall;
    logic [CNT_W-1:0] w_init;

    assign w_md_req   = i_ex_mult | i_ex_div;
    assign w_init     = i_ex_div ? DIV_INIT : MUL_INIT;
    assign w_md_stall = !i_md_abort &&
                        (((r_state == S_IDLE) && w_md_req) || (r_state == S_BUSY));

    // r_cnt holds the BUSY cycles still to run, counting the current one,
    // so a latency of LAT spends LAT-2 cycles in BUSY and one in DONE.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (i_md_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_req) begin
                        r_cnt   <= w_init;
                        r_state <= (w_init == '0) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_pc_wr       = 1'b1;
        o_ifid_wr     = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_wr     = 1'b1;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        o_md_busy     = 1'b0;
        o_md_done     = 1'b0;
        if (i_reset) begin
            o_pc_wr   = 1'b0;
            o_ifid_wr = 1'b0;
            o_idex_wr = 1'b0;
        end else begin
            o_md_busy = !i_md_abort && (r_state == S_BUSY);
            o_md_done = !i_md_abort && (r_state == S_DONE);
            if (w_md_stall) begin
                o_pc_wr       = 1'b0;
                o_ifid_wr     = 1'b0;
                o_idex_wr     = 1'b0;
                o_exmem_flush = 1'b1;
            end else if (i_loaduse_req || i_branch_req) begin
                // Branch outcome is not trusted while ID is held.
                o_pc_wr      = 1'b0;
                o_ifid_wr    = 1'b0;
                o_idex_flush = 1'b1;
            end else if (i_branch_taken) begin
                o_ifid_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
        end else if (!o_pc_wr && (r_stall_cycles != {PERF_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`else
    assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl against an occupancy model
module tb_pipe_stall_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
`ifdef HAZARD_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset, i_loaduse_req, i_branch_req, i_branch_taken;
    logic        i_ex_mult, i_ex_div, i_md_abort;
    logic        o_pc_wr, o_ifid_wr, o_ifid_flush, o_idex_wr, o_idex_flush;
    logic        o_exmem_flush, o_md_busy, o_md_done;
    logic [31:0] o_stall_cycles;

    pipe_stall_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6), .PERF_W(32)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_loaduse_req(i_loaduse_req),
        .i_branch_req(i_branch_req), .i_branch_taken(i_branch_taken),
        .i_ex_mult(i_ex_mult), .i_ex_div(i_ex_div), .i_md_abort(i_md_abort),
        .o_pc_wr(o_pc_wr), .o_ifid_wr(o_ifid_wr), .o_ifid_flush(o_ifid_flush),
        .o_idex_wr(o_idex_wr), .o_idex_flush(o_idex_flush), .o_exmem_flush(o_exmem_flush),
        .o_md_busy(o_md_busy), .o_md_done(o_md_done), .o_stall_cycles(o_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [31:0] perf;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          md_left = 0;      // EX cycles still owed by the current mult/div, DONE included
    logic [31:0] perf = 0;
    logic        hold_m = 0, hold_d = 0;

    function automatic logic [7:0] got_ctl();
        return {o_pc_wr, o_ifid_wr, o_ifid_flush, o_idex_wr, o_idex_flush,
                o_exmem_flush, o_md_busy, o_md_done};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (got_ctl() !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl t=%0t got=%b exp=%b", $time, got_ctl(), e.ctl);
                end
                checks++;
                if (o_stall_cycles !== e.perf) begin
                    errors++;
                    $display("FAIL perf t=%0t got=%0d exp=%0d", $time, o_stall_cycles, e.perf);
                end
            end
        end
    end

    task automatic cycle(input logic lu, br, bt, em, ed, ab);
        logic stall, busy, done, pc, ifid, ifl, idw, idf, exf;
        exp_t e;
        @(posedge clk);
        #1;
        i_loaduse_req = lu; i_branch_req = br; i_branch_taken = bt;
        i_ex_mult = em; i_ex_div = ed; i_md_abort = ab;
        stall = ab ? 1'b0 : ((md_left == 0) ? (em | ed) : (md_left >= 2));
        busy  = !ab && (md_left >= 2);
        done  = !ab && (md_left == 1);
        pc = 1; ifid = 1; ifl = 0; idw = 1; idf = 0; exf = 0;
        if (stall) begin
            pc = 0; ifid = 0; idw = 0; exf = 1;
        end else if (lu | br) begin
            pc = 0; ifid = 0; idf = 1;
        end else if (bt) begin
            ifl = 1;
        end
        e.ctl  = {pc, ifid, ifl, idw, idf, exf, busy, done};
        e.perf = PERF_EN ? perf : 32'd0;
        q.push_back(e);
        if (ab) md_left = 0;
        else if (md_left == 0) md_left = (em | ed) ? ((ed ? DIV_LAT : MUL_LAT) - 1) : 0;
        else md_left = md_left - 1;
        if (!pc && perf != 32'hFFFF_FFFF) perf = perf + 1;
    endtask

    task automatic direct_check(input string name, input logic [7:0] exp_ctl);
        checks++;
        if (got_ctl() !== exp_ctl) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got_ctl(), exp_ctl);
        end
        checks++;
        if (o_stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL %s_perf got=%0d exp=0", name, o_stall_cycles);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        i_reset = 1; i_loaduse_req = 0; i_branch_req = 0; i_branch_taken = 0;
        i_ex_mult = 0; i_ex_div = 0; i_md_abort = 0;
        #12;
        direct_check("reset_hold", 8'b0);
        @(posedge clk);
        #1 i_reset = 0;
        md_left = 0; perf = 0;

        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(1, 0, 1, 1, 0, 0);
        repeat (4) cycle(0, 0, 1, 1, 1, 0);

        for (int n = 0; n < 400; n++) begin
            if (md_left <= 1) begin
                hold_m = 0; hold_d = 0;
                if ($urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 2) == 0) hold_d = 1;
                    else hold_m = 1;
                end
            end
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, hold_m, hold_d,
                  $urandom_range(0, 49) == 0);
        end

        cycle(0, 0, 0, 0, 0, 1);
        repeat (21) cycle(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1 i_reset = 1;
        #1 direct_check("async_reset", 8'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        direct_check("reset_clear", 8'b0);
        #1;
        i_ex_div = 0; i_reset = 0;
        md_left = 0; perf = 0;
        cycle(0, 0, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
